// File: rtl/auto_contrast_pkg.sv
// Shared constants, state type and level-mapping helpers for the auto-contrast controller.
// Build option: AUTO_CONTRAST_SLEW_EN limits each automatic update to a +/-1 level step.
package auto_contrast_pkg;

  localparam logic [3:0] LEVEL_NEUTRAL = 4'd8;

  localparam logic [7:0] SPREAD_TH_L8  = 8'd224;
  localparam logic [7:0] SPREAD_TH_L9  = 8'd192;
  localparam logic [7:0] SPREAD_TH_L10 = 8'd160;
  localparam logic [7:0] SPREAD_TH_L11 = 8'd128;
  localparam logic [7:0] SPREAD_TH_L12 = 8'd112;
  localparam logic [7:0] SPREAD_TH_L13 = 8'd96;
  localparam logic [7:0] SPREAD_TH_L14 = 8'd80;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StUpdate
  } state_e;

  // Narrow luma spread means a flat image, so it gets a stronger contrast boost.
  function automatic logic [3:0] spread_to_level(input logic [7:0] spread);
    logic [3:0] lvl;
    if (spread >= SPREAD_TH_L8) begin
      lvl = 4'd8;
    end else if (spread >= SPREAD_TH_L9) begin
      lvl = 4'd9;
    end else if (spread >= SPREAD_TH_L10) begin
      lvl = 4'd10;
    end else if (spread >= SPREAD_TH_L11) begin
      lvl = 4'd11;
    end else if (spread >= SPREAD_TH_L12) begin
      lvl = 4'd12;
    end else if (spread >= SPREAD_TH_L13) begin
      lvl = 4'd13;
    end else if (spread >= SPREAD_TH_L14) begin
      lvl = 4'd14;
    end else begin
      lvl = 4'd15;
    end
    return lvl;
  endfunction

  function automatic logic [3:0] slew_step(input logic [3:0] cur, input logic [3:0] tgt);
    logic [3:0] nxt;
    if (cur < tgt) begin
      nxt = cur + 4'd1;
    end else if (cur > tgt) begin
      nxt = cur - 4'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/auto_contrast_ctrl_if.sv
// Pixel/control bundle of the auto-contrast controller; master drives pixels, slave is the block.
interface auto_contrast_ctrl_if;

  logic       frame_start;
  logic       pixel_valid;
  logic [7:0] raw_VGA_R;
  logic [7:0] raw_VGA_G;
  logic [7:0] raw_VGA_B;
  logic       auto_en;
  logic [3:0] manual_level;
  logic [3:0] contrast_level;
  logic       level_valid;
  logic [7:0] stat_min;
  logic [7:0] stat_max;

  modport master (
    output frame_start,
    output pixel_valid,
    output raw_VGA_R,
    output raw_VGA_G,
    output raw_VGA_B,
    output auto_en,
    output manual_level,
    input  contrast_level,
    input  level_valid,
    input  stat_min,
    input  stat_max
  );

  modport slave (
    input  frame_start,
    input  pixel_valid,
    input  raw_VGA_R,
    input  raw_VGA_G,
    input  raw_VGA_B,
    input  auto_en,
    input  manual_level,
    output contrast_level,
    output level_valid,
    output stat_min,
    output stat_max
  );

endinterface

// File: rtl/luma_calc.sv
// Combinational luma approximation Y = (R + 2G + B) / 4, truncated.
module luma_calc (
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  logic [9:0] sum;

  always_comb begin
    sum = {2'b00, r_i} + {1'b0, g_i, 1'b0} + {2'b00, b_i};
  end

  assign y_o = 8'(sum >> 2);

endmodule

// File: rtl/auto_contrast_ctrl.sv
// Per-frame luma min/max statistics driving an automatic or manual contrast level.
// Build option: AUTO_CONTRAST_SLEW_EN makes automatic updates step by at most one level.
module auto_contrast_ctrl
  import auto_contrast_pkg::*;
(
  input  logic                 VGA_CLK,
  input  logic                 reset,
  auto_contrast_ctrl_if.slave  acc_if
);

  logic [7:0] luma;

  luma_calc u_luma_calc (
    .r_i (acc_if.raw_VGA_R),
    .g_i (acc_if.raw_VGA_G),
    .b_i (acc_if.raw_VGA_B),
    .y_o (luma)
  );

  state_e     state_q, state_d;
  logic [7:0] acc_min_q, acc_min_d;
  logic [7:0] acc_max_q, acc_max_d;
  logic       seen_q, seen_d;
  logic [7:0] snap_min_q, snap_min_d;
  logic [7:0] snap_max_q, snap_max_d;
  logic       snap_seen_q, snap_seen_d;
  logic [3:0] level_q, level_d;
  logic       level_valid_q, level_valid_d;

  logic [7:0] spread;
  logic [3:0] target;
  logic [3:0] level_new;

  assign spread = snap_max_q - snap_min_q;
  assign target = spread_to_level(spread);

`ifdef AUTO_CONTRAST_SLEW_EN
  assign level_new = slew_step(level_q, target);
`else
  assign level_new = target;
`endif

  always_comb begin
    state_d       = state_q;
    acc_min_d     = acc_min_q;
    acc_max_d     = acc_max_q;
    seen_d        = seen_q;
    snap_min_d    = snap_min_q;
    snap_max_d    = snap_max_q;
    snap_seen_d   = snap_seen_q;
    level_d       = level_q;
    level_valid_d = 1'b0;

    if (!acc_if.auto_en) begin
      level_d = acc_if.manual_level;
    end else if (state_q == StUpdate && snap_seen_q) begin
      level_d       = level_new;
      level_valid_d = 1'b1;
    end

    if (state_q != StIdle && acc_if.pixel_valid) begin
      acc_min_d = (luma < acc_min_q) ? luma : acc_min_q;
      acc_max_d = (luma > acc_max_q) ? luma : acc_max_q;
      seen_d    = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (acc_if.frame_start) state_d = StAccum;
      end
      StAccum, StUpdate: begin
        if (acc_if.frame_start) begin
          snap_min_d  = acc_min_q;
          snap_max_d  = acc_max_q;
          snap_seen_d = seen_q;
          // A pixel on the frame_start cycle opens the new frame.
          if (acc_if.pixel_valid) begin
            acc_min_d = luma;
            acc_max_d = luma;
            seen_d    = 1'b1;
          end else begin
            acc_min_d = 8'hFF;
            acc_max_d = 8'h00;
            seen_d    = 1'b0;
          end
          state_d = StUpdate;
        end else if (state_q == StUpdate) begin
          state_d = StAccum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q       <= StIdle;
      acc_min_q     <= 8'hFF;
      acc_max_q     <= 8'h00;
      seen_q        <= 1'b0;
      snap_min_q    <= 8'h00;
      snap_max_q    <= 8'h00;
      snap_seen_q   <= 1'b0;
      level_q       <= LEVEL_NEUTRAL;
      level_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_min_q     <= acc_min_d;
      acc_max_q     <= acc_max_d;
      seen_q        <= seen_d;
      snap_min_q    <= snap_min_d;
      snap_max_q    <= snap_max_d;
      snap_seen_q   <= snap_seen_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  // The snapshot registers are the published statistics of the last completed frame.
  assign acc_if.contrast_level = level_q;
  assign acc_if.level_valid    = level_valid_q;
  assign acc_if.stat_min       = snap_min_q;
  assign acc_if.stat_max       = snap_max_q;

endmodule

// File: tb/tb_auto_contrast_ctrl.sv
// Self-checking bench: directed table, hand sequences and a random run against a frame-level model.
module tb_auto_contrast_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  auto_contrast_ctrl_if bus ();

  auto_contrast_ctrl dut (
    .VGA_CLK (clk),
    .reset   (rst),
    .acc_if  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level reference model
  int q_luma[$];
  bit started;
  bit pend, p_seen;
  int p_min, p_max;
  int m_level, m_valid, m_smin, m_smax;

  bit cur_ae = 1'b1;
  int cur_ml = 0;

  typedef struct {
    bit r;
    bit fs;
    bit pv;
    int y;
    int lvl;
    int vld;
    int smin;
    int smax;
  } vec_t;

  vec_t tbl[7];

  function automatic int luma_of(int r, int g, int b);
    return (r + 2 * g + b) / 4;
  endfunction

  function automatic int target_of(int spread);
    if (spread >= 224) return 8;
    if (spread >= 192) return 9;
    if (spread >= 160) return 10;
    if (spread >= 128) return 11;
    if (spread >= 112) return 12;
    if (spread >= 96) return 13;
    if (spread >= 80) return 14;
    return 15;
  endfunction

  function automatic int next_level(int cur, int tgt);
`ifdef AUTO_CONTRAST_SLEW_EN
    if (tgt > cur) return cur + 1;
    if (tgt < cur) return cur - 1;
    return cur;
`else
    return tgt;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit fs, input bit pv, input int y, input bit ae,
                            input int ml);
    if (r) begin
      q_luma.delete();
      started = 0;
      pend = 0;
      m_level = 8;
      m_valid = 0;
      m_smin = 0;
      m_smax = 0;
    end else begin
      if (!ae) begin
        m_level = ml;
        m_valid = 0;
      end else if (pend && p_seen) begin
        m_level = next_level(m_level, target_of(p_max - p_min));
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      pend = 0;
      if (fs) begin
        if (started) begin
          p_seen = q_luma.size() > 0;
          p_min = 255;
          p_max = 0;
          foreach (q_luma[i]) begin
            if (q_luma[i] < p_min) p_min = q_luma[i];
            if (q_luma[i] > p_max) p_max = q_luma[i];
          end
          m_smin = p_min;
          m_smax = p_max;
          pend = 1;
          q_luma.delete();
          if (pv) q_luma.push_back(y);
        end else begin
          started = 1;
        end
      end else if (pv && started) begin
        q_luma.push_back(y);
      end
    end
  endtask

  task automatic step(input bit r, input bit fs, input bit pv, input int cr, input int cg,
                      input int cb, input bit check_model);
    @(negedge clk);
    rst              = r;
    bus.frame_start  = fs;
    bus.pixel_valid  = pv;
    bus.raw_VGA_R    = 8'(cr);
    bus.raw_VGA_G    = 8'(cg);
    bus.raw_VGA_B    = 8'(cb);
    bus.auto_en      = cur_ae;
    bus.manual_level = 4'(cur_ml);
    @(posedge clk);
    #1;
    model_edge(r, fs, pv, luma_of(cr, cg, cb), cur_ae, cur_ml);
    if (check_model) begin
      chk("contrast_level", int'(bus.contrast_level), m_level);
      chk("level_valid", int'(bus.level_valid), m_valid);
      chk("stat_min", int'(bus.stat_min), m_smin);
      chk("stat_max", int'(bus.stat_max), m_smax);
    end
  endtask

  // Gray pixel so that luma equals y.
  task automatic cyc(input bit r, input bit fs, input bit pv, input int y);
    step(r, fs, pv, y, y, y, 1'b1);
  endtask

  function automatic int clamp8(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  int center, width;
  int exp_lvl;

  initial begin
    bus.frame_start  = 1'b0;
    bus.pixel_valid  = 1'b0;
    bus.raw_VGA_R    = 8'd0;
    bus.raw_VGA_G    = 8'd0;
    bus.raw_VGA_B    = 8'd0;
    bus.auto_en      = 1'b1;
    bus.manual_level = 4'd0;

    // reset, frame_start, pixels Y=0 and Y=255, frame_start, update
    tbl[0] = '{r: 1, fs: 1, pv: 0, y: 0,   lvl: 8, vld: 0, smin: 0, smax: 0};
    tbl[1] = '{r: 0, fs: 1, pv: 0, y: 0,   lvl: 8, vld: 0, smin: 0, smax: 0};
    tbl[2] = '{r: 0, fs: 0, pv: 1, y: 0,   lvl: 8, vld: 0, smin: 0, smax: 0};
    tbl[3] = '{r: 0, fs: 0, pv: 1, y: 255, lvl: 8, vld: 0, smin: 0, smax: 0};
    tbl[4] = '{r: 0, fs: 1, pv: 0, y: 0,   lvl: 8, vld: 0, smin: 0, smax: 255};
    tbl[5] = '{r: 0, fs: 0, pv: 0, y: 0,   lvl: 8, vld: 1, smin: 0, smax: 255};
    tbl[6] = '{r: 0, fs: 0, pv: 0, y: 0,   lvl: 8, vld: 0, smin: 0, smax: 255};

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].fs, tbl[i].pv, tbl[i].y, tbl[i].y, tbl[i].y, 1'b0);
      chk($sformatf("tbl%0d.level", i), int'(bus.contrast_level), tbl[i].lvl);
      chk($sformatf("tbl%0d.valid", i), int'(bus.level_valid), tbl[i].vld);
      chk($sformatf("tbl%0d.min", i), int'(bus.stat_min), tbl[i].smin);
      chk($sformatf("tbl%0d.max", i), int'(bus.stat_max), tbl[i].smax);
    end

    // Seven identical frames with luma spread 100..150
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 1, 100);
      cyc(0, 0, 1, 125);
      cyc(0, 0, 1, 150);
      cyc(0, 1, 0, 0);
      chk("spread50.min", int'(bus.stat_min), 100);
      chk("spread50.max", int'(bus.stat_max), 150);
      cyc(0, 0, 0, 0);
`ifdef AUTO_CONTRAST_SLEW_EN
      exp_lvl = 9 + k;
`else
      exp_lvl = 15;
`endif
      chk("spread50.level", int'(bus.contrast_level), exp_lvl);
      chk("spread50.valid", int'(bus.level_valid), 1);
    end

    // Frame with no valid pixels
    for (int i = 0; i < 5; i++) step(0, 0, 0, 7, 99, 201, 1'b1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("empty.level", int'(bus.contrast_level), 15);
    chk("empty.valid", int'(bus.level_valid), 0);
    chk("empty.min", int'(bus.stat_min), 255);
    chk("empty.max", int'(bus.stat_max), 0);

    // Manual mode, then switch to auto with a spread-200 frame
    cur_ae = 1'b0;
    cur_ml = 3;
    cyc(0, 0, 0, 0);
    chk("manual.level", int'(bus.contrast_level), 3);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 50);
    cyc(0, 0, 1, 60);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("manual.valid", int'(bus.level_valid), 0);
    chk("manual.hold", int'(bus.contrast_level), 3);
    cur_ae = 1'b1;
    cyc(0, 0, 1, 20);
    cyc(0, 0, 1, 220);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef AUTO_CONTRAST_SLEW_EN
    exp_lvl = 4;
`else
    exp_lvl = 9;
`endif
    chk("auto_resume.level", int'(bus.contrast_level), exp_lvl);
    chk("auto_resume.valid", int'(bus.level_valid), 1);

    // Pixel coincident with frame_start belongs to the new frame
    cyc(0, 0, 1, 100);
    cyc(0, 0, 1, 200);
    cyc(0, 1, 1, 40);
    chk("coinc.old_min", int'(bus.stat_min), 100);
    chk("coinc.old_max", int'(bus.stat_max), 200);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("coinc.new_min", int'(bus.stat_min), 40);
    chk("coinc.new_max", int'(bus.stat_max), 40);
    cyc(0, 0, 0, 0);

    // frame_start while in UPDATE
    cyc(0, 0, 1, 30);
    cyc(0, 0, 1, 90);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 60);
    chk("b2b.valid", int'(bus.level_valid), 1);
    chk("b2b.min", int'(bus.stat_min), 255);
    cyc(0, 0, 0, 0);
    chk("b2b.empty_valid", int'(bus.level_valid), 0);

    // Reset mid-frame discards the partial statistics
    cyc(0, 0, 1, 10);
    cyc(0, 0, 1, 250);
    cyc(1, 1, 1, 5);
    chk("midrst.level", int'(bus.contrast_level), 8);
    chk("midrst.min", int'(bus.stat_min), 0);
    cyc(0, 0, 1, 5);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("midrst.idle_valid", int'(bus.level_valid), 0);
    cyc(0, 0, 1, 100);
    cyc(0, 0, 1, 120);
    cyc(0, 1, 0, 0);
    chk("midrst.min2", int'(bus.stat_min), 100);
    chk("midrst.max2", int'(bus.stat_max), 120);
    cyc(0, 0, 0, 0);
    chk("midrst.valid2", int'(bus.level_valid), 1);

    // Randomized traffic against the model
    center = 128;
    width = 40;
    for (int n = 0; n < 5000; n++) begin
      bit r, fs, pv;
      r  = ($urandom_range(0, 799) == 0);
      fs = ($urandom_range(0, 19) == 0);
      pv = ($urandom_range(0, 9) < 7);
      if (fs) begin
        center = $urandom_range(0, 255);
        width  = $urandom_range(0, 130);
      end
      if ($urandom_range(0, 299) == 0) cur_ae = ~cur_ae;
      if ($urandom_range(0, 49) == 0) cur_ml = $urandom_range(0, 15);
      step(r, fs, pv,
           clamp8(center + $urandom_range(0, 2 * width) - width),
           clamp8(center + $urandom_range(0, 2 * width) - width),
           clamp8(center + $urandom_range(0, 2 * width) - width), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
